// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall scheduler: state encodings and widths.
package pipe_stall_ctrl_pkg;

  localparam logic [1:0] PSC_ST_RUN  = 2'b00;
  localparam logic [1:0] PSC_ST_DHAZ = 2'b01;
  localparam logic [1:0] PSC_ST_MEMW = 2'b10;

  typedef enum logic [1:0] {
    StRun  = PSC_ST_RUN,
    StDhaz = PSC_ST_DHAZ,
    StMemw = PSC_ST_MEMW
  } psc_state_e;

  // Hazard counter covers WB_DIST up to 15, watchdog covers MEM_TIMEOUT up to 255.
  localparam int unsigned PscCntW = 4;
  localparam int unsigned PscWdW  = 8;
  localparam int unsigned PscPerfW = 16;

  // Saturating increment for the 16-bit performance counters.
  function automatic logic [PscPerfW-1:0] psc_sat_inc(input logic [PscPerfW-1:0] val);
    return (val == '1) ? val : val + 1'b1;
  endfunction

endpackage

// File: rtl/pipe_wdog.sv
// Memory-wait watchdog: counts wait cycles and raises a sticky timeout flag.
module pipe_wdog
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic tick_i,
  output logic err_o
);

  localparam logic [PscWdW-1:0] Limit = PscWdW'(MEM_TIMEOUT);

  logic [PscWdW-1:0] wd_q, wd_d;
  logic              err_q, err_d;

  // Next-state: clear outside a wait, count up to the limit, flag once the limit is held.
  always_comb begin
    wd_d  = wd_q;
    err_d = err_q;
    if (clr_i) begin
      wd_d = '0;
    end else if (tick_i) begin
      if (wd_q == Limit) begin
        err_d = 1'b1;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end
  end

  // Watchdog count and sticky flag; the flag clears only on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall scheduler: converts decoder conflicts and memory waits into
// stall/hold controls, counts the hazard penalty and resumes it after memory waits.
// Optional feature macro: PIPE_STALL_CTRL_PERF_EN adds perf_haz_o / perf_mem_o counters.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int unsigned WB_DIST     = 3,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        d_conflict_i,
  input  logic        mem_req_i,
  input  logic        mem_ready_i,
  output logic        stall_if_o,
  output logic        stall_dec_o,
  output logic        hold_o,
  output logic [1:0]  state_o,
`ifdef PIPE_STALL_CTRL_PERF_EN
  output logic [15:0] perf_haz_o,
  output logic [15:0] perf_mem_o,
`endif
  output logic        mem_err_o
);

  localparam logic [PscCntW-1:0] CntInit = PscCntW'(WB_DIST - 1);
  localparam bit                 MultiCycle = (WB_DIST > 1);

  psc_state_e         state_q, ret_q, eff;
  logic [PscCntW-1:0] cnt_q;
  logic               mem_wait;
  logic               stall;

  assign mem_wait = mem_req_i & ~mem_ready_i;

  // While waiting on memory the interrupted state is carried in ret_q.
  assign eff = (state_q == StMemw) ? ret_q : state_q;

  // Zero-latency stall/hold, gated off while reset is asserted.
  always_comb begin
    stall = mem_wait | (eff == StDhaz) | ((eff == StRun) & d_conflict_i);
    stall_if_o  = rst_n & stall;
    stall_dec_o = rst_n & stall;
    hold_o      = rst_n & mem_wait;
  end

  assign state_o = state_q;

  // FSM and hazard counter; memory waits freeze the hazard count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      ret_q   <= StRun;
      cnt_q   <= '0;
    end else if (mem_wait) begin
      state_q <= StMemw;
      ret_q   <= eff;
    end else begin
      unique case (eff)
        StRun: begin
          if (d_conflict_i && MultiCycle) begin
            state_q <= StDhaz;
            cnt_q   <= CntInit;
          end else begin
            state_q <= StRun;
          end
        end
        StDhaz: begin
          if (cnt_q == PscCntW'(1)) begin
            state_q <= StRun;
          end else begin
            state_q <= StDhaz;
            cnt_q   <= cnt_q - 1'b1;
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

  // Watchdog counts every wait cycle, including the one that enters MEMW.
  pipe_wdog #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wdog (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (~mem_wait),
    .tick_i(mem_wait),
    .err_o (mem_err_o)
  );

`ifdef PIPE_STALL_CTRL_PERF_EN
  logic [PscPerfW-1:0] perf_haz_q, perf_mem_q;

  // Saturating cycle counters for hazard-only stalls and memory waits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_haz_q <= '0;
      perf_mem_q <= '0;
    end else begin
      if (stall_dec_o && !mem_wait) perf_haz_q <= psc_sat_inc(perf_haz_q);
      if (mem_wait)                 perf_mem_q <= psc_sat_inc(perf_mem_q);
    end
  end

  assign perf_haz_o = perf_haz_q;
  assign perf_mem_o = perf_mem_q;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: directed cycles push expectations,
// a negedge monitor pops and compares. A second instance covers WB_DIST=1.
module tb_pipe_stall_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic conf = 1'b0, req = 1'b0, rdy = 1'b0;

  logic       s_if, s_dec, hold, err;
  logic [1:0] st;
  logic       s_if1, s_dec1, hold1, err1;
  logic [1:0] st1;
`ifdef PIPE_STALL_CTRL_PERF_EN
  logic [15:0] ph, pm, ph1, pm1;
`endif

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    string      nm;
    logic [5:0] exp;
    logic       exp1;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.WB_DIST(3), .MEM_TIMEOUT(4)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .d_conflict_i(conf),
    .mem_req_i   (req),
    .mem_ready_i (rdy),
    .stall_if_o  (s_if),
    .stall_dec_o (s_dec),
    .hold_o      (hold),
    .state_o     (st),
`ifdef PIPE_STALL_CTRL_PERF_EN
    .perf_haz_o  (ph),
    .perf_mem_o  (pm),
`endif
    .mem_err_o   (err)
  );

  pipe_stall_ctrl #(.WB_DIST(1), .MEM_TIMEOUT(4)) u_dut1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .d_conflict_i(conf),
    .mem_req_i   (req),
    .mem_ready_i (rdy),
    .stall_if_o  (s_if1),
    .stall_dec_o (s_dec1),
    .hold_o      (hold1),
    .state_o     (st1),
`ifdef PIPE_STALL_CTRL_PERF_EN
    .perf_haz_o  (ph1),
    .perf_mem_o  (pm1),
`endif
    .mem_err_o   (err1)
  );

  function automatic void chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endfunction

  // Monitor: one expectation per driven cycle, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk(e.nm, {10'd0, s_if, s_dec, hold, st, err}, {10'd0, e.exp});
      chk({e.nm, "/wb1"}, {15'd0, s_dec1}, {15'd0, e.exp1});
    end
  end

  // Drive one cycle of inputs and queue the hand-computed response.
  task automatic cyc(input logic c, input logic r, input logic y, input logic es,
                     input logic eh, input logic [1:0] est, input logic ee, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    conf = c;
    req  = r;
    rdy  = y;
    e.nm   = nm;
    e.exp  = {es, es, eh, est, ee};
    // WB_DIST=1 never enters DHAZ, so it stalls only on conflict or wait.
    e.exp1 = c | (r & ~y);
    q.push_back(e);
  endtask

  task automatic rst_chk(input string nm);
    chk(nm, {10'd0, s_if, s_dec, hold, st, err}, 16'd0);
    chk({nm, "/wb1"}, {10'd0, s_if1, s_dec1, hold1, st1, err1}, 16'd0);
  endtask

  initial begin
    // Outputs gated during reset even with every input asserted.
    conf = 1'b1; req = 1'b1; rdy = 1'b0;
    #12;
    rst_chk("rst_gate");
    conf = 1'b0; req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    repeat (5) cyc(0, 0, 0, 0, 0, 2'b00, 0, "idle");

    // Single conflict pulse: stall t..t+2, DHAZ at t+1,t+2.
    cyc(1, 0, 0, 1, 0, 2'b00, 0, "haz_t");
    cyc(0, 0, 0, 1, 0, 2'b01, 0, "haz_t1");
    cyc(0, 0, 0, 1, 0, 2'b01, 0, "haz_t2");
    cyc(0, 0, 0, 0, 0, 2'b00, 0, "haz_t3");
`ifdef PIPE_STALL_CTRL_PERF_EN
    @(negedge clk);
    #1;
    chk("perf_haz", ph, 16'd3);
    chk("perf_mem", pm, 16'd0);
`endif

    // Held conflict: ignored in DHAZ, re-sampled on the first RUN cycle.
    cyc(1, 0, 0, 1, 0, 2'b00, 0, "held_t");
    cyc(1, 0, 0, 1, 0, 2'b01, 0, "held_t1");
    cyc(1, 0, 0, 1, 0, 2'b01, 0, "held_t2");
    cyc(1, 0, 0, 1, 0, 2'b00, 0, "held_resample");
    cyc(0, 0, 0, 1, 0, 2'b01, 0, "held_t4");
    cyc(0, 0, 0, 1, 0, 2'b01, 0, "held_t5");
    cyc(0, 0, 0, 0, 0, 2'b00, 0, "held_t6");

    // Four-cycle memory wait, released same cycle as ready.
    cyc(0, 1, 0, 1, 1, 2'b00, 0, "mem_w1");
    cyc(0, 1, 0, 1, 1, 2'b10, 0, "mem_w2");
    cyc(0, 1, 0, 1, 1, 2'b10, 0, "mem_w3");
    cyc(0, 1, 0, 1, 1, 2'b10, 0, "mem_w4");
    cyc(0, 1, 1, 0, 0, 2'b10, 0, "mem_ready");
    cyc(0, 0, 0, 0, 0, 2'b00, 0, "mem_after");

    // Request dropped without ready counts as completion.
    cyc(0, 1, 0, 1, 1, 2'b00, 0, "drop_w");
    cyc(0, 0, 0, 0, 0, 2'b10, 0, "drop_rel");
    cyc(0, 0, 0, 0, 0, 2'b00, 0, "drop_after");

    // Conflict at t with a two-cycle wait at t+1: stall t..t+4.
    cyc(1, 0, 0, 1, 0, 2'b00, 0, "hm_t");
    cyc(0, 1, 0, 1, 1, 2'b01, 0, "hm_t1");
    cyc(0, 1, 0, 1, 1, 2'b10, 0, "hm_t2");
    cyc(0, 0, 0, 1, 0, 2'b10, 0, "hm_t3");
    cyc(0, 0, 0, 1, 0, 2'b01, 0, "hm_t4");
    cyc(0, 0, 0, 0, 0, 2'b00, 0, "hm_t5");

    // Reset in the middle of DHAZ abandons it immediately.
    cyc(1, 0, 0, 1, 0, 2'b00, 0, "mr_t");
    cyc(0, 0, 0, 1, 0, 2'b01, 0, "mr_dhaz");
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    conf = 1'b1; req = 1'b1;
    #1;
    rst_chk("mr_reset");
    conf = 1'b0; req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0, 2'b00, 0, "mr_after");

    // Watchdog with limit 4: flag rises at the edge after the 5th wait cycle.
    cyc(0, 1, 0, 1, 1, 2'b00, 0, "to_w1");
    cyc(0, 1, 0, 1, 1, 2'b10, 0, "to_w2");
    cyc(0, 1, 0, 1, 1, 2'b10, 0, "to_w3");
    cyc(0, 1, 0, 1, 1, 2'b10, 0, "to_w4");
    cyc(0, 1, 0, 1, 1, 2'b10, 0, "to_w5");
    cyc(0, 1, 0, 1, 1, 2'b10, 1, "to_w6");
    cyc(0, 1, 1, 0, 0, 2'b10, 1, "to_ready");
    cyc(0, 0, 0, 0, 0, 2'b00, 1, "to_sticky");
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    rst_chk("to_reset_clr");
    @(negedge clk);
    rst_n = 1'b1;

`ifdef PIPE_STALL_CTRL_PERF_EN
    @(posedge clk);
    #1;
    req = 1'b1; rdy = 1'b0;
    repeat (70000) @(posedge clk);
    #1;
    chk("perf_mem_sat", pm, 16'hFFFF);
    chk("perf_haz_wait", ph, 16'd0);
    req = 1'b0;
`endif

    repeat (2) @(posedge clk);
    chk("sb_drain", 16'(q.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
